// File: rtl/sum_mult_e_requant_pkg.sv
// Shared constants for the product requantizer: lane geometry, mode encodings,
// clamp limits and the shift ceiling.
package sum_mult_e_requant_pkg;

    localparam int COLUMN_NUM_IN_SA      = 16;
    localparam int PE_PARALLEL_PIXEL     = 2;
    localparam int PE_PARALLEL_WEIGHT_18 = 2;
    localparam int MULT_P_WIDTH          = 40;
    localparam int SHIFT_WIDTH           = 6;
    localparam int OUT_WIDTH_88          = 16;
    localparam int OUT_WIDTH_18          = 8;
    localparam int SAT_CNT_WIDTH         = 16;
    localparam int MODE_W                = 4;

    localparam int LANE_NUM         = PE_PARALLEL_PIXEL * COLUMN_NUM_IN_SA * PE_PARALLEL_WEIGHT_18;
    localparam int OUT_VECTOR_WIDTH = LANE_NUM * OUT_WIDTH_18;
    localparam int EXT_W            = MULT_P_WIDTH + 1;
    localparam int MODE18_P_W       = 32;

    localparam logic [SHIFT_WIDTH-1:0] SHIFT_MAX = 6'd39;

    localparam int MAX_88 = 32767;
    localparam int MIN_88 = -32768;
    localparam int MAX_18 = 127;
    localparam int MIN_18 = -128;

    typedef enum logic [MODE_W-1:0] {
        MODE_88 = 4'd0,
        MODE_18 = 4'd1
    } mode_e;

endpackage

// File: rtl/requant_lane.sv
// One product lane: operand select, rounding right-shift (stage-1 register),
// then signed clamp to the output width selected by the registered mode.
module requant_lane
    import sum_mult_e_requant_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic [MODE_W-1:0]         mode,
    input  logic [MODE_W-1:0]         mode_p1,
    input  logic [MULT_P_WIDTH-1:0]   p,
    input  logic [2*SHIFT_WIDTH-1:0]  shift_set,
    output logic [OUT_WIDTH_88-1:0]   q,
    output logic                      sat
);

    localparam bit HI_LANE = (LANE >= LANE_NUM / 2);

    localparam logic signed [EXT_W-1:0] ONE   = EXT_W'(1);
    localparam logic signed [EXT_W-1:0] HI_88 = EXT_W'(MAX_88);
    localparam logic signed [EXT_W-1:0] LO_88 = EXT_W'(MIN_88);
    localparam logic signed [EXT_W-1:0] HI_18 = EXT_W'(MAX_18);
    localparam logic signed [EXT_W-1:0] LO_18 = EXT_W'(MIN_18);

    // Round half toward +inf; 41 bits leave headroom for the half-LSB add.
    function automatic logic signed [EXT_W-1:0] round_shift(
        input logic signed [EXT_W-1:0]  x,
        input logic [SHIFT_WIDTH-1:0]   s
    );
        logic signed [EXT_W-1:0] half;
        half = (s == '0) ? '0 : (ONE <<< (s - SHIFT_WIDTH'(1)));
        return (x + half) >>> s;
    endfunction

    function automatic logic [OUT_WIDTH_88-1:0] clamp_88(input logic signed [EXT_W-1:0] r);
        if (r > HI_88) return HI_88[OUT_WIDTH_88-1:0];
        if (r < LO_88) return LO_88[OUT_WIDTH_88-1:0];
        return r[OUT_WIDTH_88-1:0];
    endfunction

    function automatic logic [OUT_WIDTH_18-1:0] clamp_18(input logic signed [EXT_W-1:0] r);
        if (r > HI_18) return HI_18[OUT_WIDTH_18-1:0];
        if (r < LO_18) return LO_18[OUT_WIDTH_18-1:0];
        return r[OUT_WIDTH_18-1:0];
    endfunction

    function automatic logic out_of_range(
        input logic signed [EXT_W-1:0] r,
        input logic signed [EXT_W-1:0] lo,
        input logic signed [EXT_W-1:0] hi
    );
        return (r > hi) || (r < lo);
    endfunction

    logic signed [EXT_W-1:0]  x_p0;
    logic [SHIFT_WIDTH-1:0]   s_raw_p0;
    logic [SHIFT_WIDTH-1:0]   s_p0;
    logic signed [EXT_W-1:0]  r_p1_d;
    logic signed [EXT_W-1:0]  r_p1_q;

    always_comb begin
        x_p0     = '0;
        s_raw_p0 = shift_set[SHIFT_WIDTH-1:0];
        if (mode == MODE_88 && !HI_LANE) begin
            x_p0 = {p[MULT_P_WIDTH-1], p};
        end else if (mode == MODE_18) begin
            x_p0 = {{(EXT_W-MODE18_P_W){p[MODE18_P_W-1]}}, p[MODE18_P_W-1:0]};
            if (HI_LANE) s_raw_p0 = shift_set[2*SHIFT_WIDTH-1:SHIFT_WIDTH];
        end
        s_p0   = (s_raw_p0 > SHIFT_MAX) ? SHIFT_MAX : s_raw_p0;
        r_p1_d = round_shift(x_p0, s_p0);
    end

    // Stage 1 boundary: rounded result, held while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (en) r_p1_q <= r_p1_d;
    end

    always_comb begin
        q   = '0;
        sat = 1'b0;
        if (mode_p1 == MODE_88) begin
            q   = clamp_88(r_p1_q);
            sat = out_of_range(r_p1_q, LO_88, HI_88);
        end else if (mode_p1 == MODE_18) begin
            q   = {{(OUT_WIDTH_88-OUT_WIDTH_18){1'b0}}, clamp_18(r_p1_q)};
            sat = out_of_range(r_p1_q, LO_18, HI_18);
        end
    end

endmodule

// File: rtl/sum_mult_e_requant.sv
// Requantizer for the 64-lane multiplier product vector: two-stage pipeline
// (round-shift, then clamp/pack) with whole-pipe stall and a saturation counter.
module sum_mult_e_requant
    import sum_mult_e_requant_pkg::*;
#(
    parameter int SAT_CNT_W = SAT_CNT_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [MODE_W-1:0]                 mode,
    input  logic [LANE_NUM*MULT_P_WIDTH-1:0]  P_vector,
    input  logic [2*SHIFT_WIDTH-1:0]          shift_set,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [OUT_VECTOR_WIDTH-1:0]       out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_sat,
    input  logic                              sat_clr,
    output logic [SAT_CNT_W-1:0]              sat_cnt
);

    logic                         adv;
    logic                         vld_p1_d, vld_p1_q;
    logic [MODE_W-1:0]            mode_p1_d, mode_p1_q;
    logic [OUT_WIDTH_88-1:0]      lane_q [LANE_NUM];
    logic [LANE_NUM-1:0]          lane_sat;
    logic                         vld_p2_d, vld_p2_q;
    logic [OUT_VECTOR_WIDTH-1:0]  data_p2_d, data_p2_q;
    logic                         sat_p2_d, sat_p2_q;
    logic [SAT_CNT_W-1:0]         sat_cnt_d, sat_cnt_q;

    assign adv      = !vld_p2_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        vld_p1_d  = vld_p1_q;
        mode_p1_d = mode_p1_q;
        if (adv) begin
            vld_p1_d  = in_valid;
            mode_p1_d = mode;
        end
    end

    // Stage 1 boundary: valid/mode travel with the per-lane rounded results.
    always_ff @(posedge clk) begin
        if (!rst_n) vld_p1_q <= 1'b0;
        else        vld_p1_q <= vld_p1_d;
    end

    always_ff @(posedge clk) begin
        mode_p1_q <= mode_p1_d;
    end

    for (genvar m = 0; m < LANE_NUM; m++) begin : g_lane
        requant_lane #(.LANE(m)) u_lane (
            .clk       (clk),
            .en        (adv),
            .mode      (mode),
            .mode_p1   (mode_p1_q),
            .p         (P_vector[m*MULT_P_WIDTH +: MULT_P_WIDTH]),
            .shift_set (shift_set),
            .q         (lane_q[m]),
            .sat       (lane_sat[m])
        );
    end

    // Inactive lanes report no saturation, so a plain OR covers active lanes only.
    always_comb begin
        data_p2_d = data_p2_q;
        sat_p2_d  = sat_p2_q;
        vld_p2_d  = vld_p2_q;
        if (adv) begin
            vld_p2_d  = vld_p1_q;
            sat_p2_d  = |lane_sat;
            data_p2_d = '0;
            if (mode_p1_q == MODE_88) begin
                for (int m = 0; m < LANE_NUM / 2; m++)
                    data_p2_d[m*OUT_WIDTH_88 +: OUT_WIDTH_88] = lane_q[m];
            end else if (mode_p1_q == MODE_18) begin
                for (int m = 0; m < LANE_NUM; m++)
                    data_p2_d[m*OUT_WIDTH_18 +: OUT_WIDTH_18] = lane_q[m][OUT_WIDTH_18-1:0];
            end
        end
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr)
            sat_cnt_d = '0;
        else if (vld_p2_q && out_ready && sat_p2_q && !(&sat_cnt_q))
            sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
    end

    // Stage 2 boundary: packed beat, its saturation flag and the debug counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            sat_p2_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            vld_p2_q  <= vld_p2_d;
            data_p2_q <= data_p2_d;
            sat_p2_q  <= sat_p2_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign out_valid = vld_p2_q;
    assign out_data  = data_p2_q;
    assign out_sat   = sat_p2_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_sum_mult_e_requant.sv
// Bench for sum_mult_e_requant: directed scenarios plus a randomized stream
// compared against an arithmetic model of the requantization rules.
module tb_sum_mult_e_requant;
    import sum_mult_e_requant_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [3:0]     mode;
    logic [2559:0]  p_vec;
    logic [11:0]    shift_set;
    logic           in_valid, out_ready, sat_clr;
    logic           in_ready, out_valid, out_sat;
    logic [511:0]   out_data;
    logic [15:0]    sat_cnt;
    logic           s_in_ready, s_out_valid, s_out_sat;
    logic [511:0]   s_out_data;
    logic [3:0]     s_sat_cnt;

    int errors = 0;
    int checks = 0;

    sum_mult_e_requant u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .P_vector(p_vec), .shift_set(shift_set),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sat(out_sat), .sat_clr(sat_clr), .sat_cnt(sat_cnt)
    );

    sum_mult_e_requant #(.SAT_CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .mode(mode), .P_vector(p_vec), .shift_set(shift_set),
        .in_valid(in_valid), .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_sat(s_out_sat), .sat_clr(sat_clr), .sat_cnt(s_sat_cnt)
    );

    // Reference: sign-extend, round half up by floor((x + 2^(s-1)) / 2^s), clamp, pack.
    function automatic void model(input logic [2559:0] p, input logic [3:0] md,
                                  input logic [11:0] sh, output logic [511:0] d, output bit sat);
        longint x, r, lo, hi;
        int s, n;
        logic [39:0] seg;
        d = '0; sat = 0;
        if (md == 4'd0) begin n = 32; lo = -32768; hi = 32767; end
        else            begin n = 64; lo = -128;   hi = 127;   end
        if (md > 4'd1) n = 0;
        for (int m = 0; m < n; m++) begin
            seg = p[m*40 +: 40];
            if (md == 4'd0) x = longint'($signed(seg));
            else            x = longint'($signed(seg[31:0]));
            s = (md == 4'd1 && m >= 32) ? int'(sh[11:6]) : int'(sh[5:0]);
            if (s > 39) s = 39;
            r = (s == 0) ? x : ((x + (longint'(1) <<< (s - 1))) >>> s);
            if (r > hi)      begin r = hi; sat = 1; end
            else if (r < lo) begin r = lo; sat = 1; end
            if (md == 4'd0) d[m*16 +: 16] = r[15:0];
            else            d[m*8 +: 8]   = r[7:0];
        end
    endfunction

    function automatic longint rand_val();
        int w;
        longint v;
        w = $urandom_range(1, 40);
        v = {$urandom, $urandom};
        v = (v <<< (64 - w)) >>> (64 - w);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_lane(input int m, input longint v);
        p_vec[m*40 +: 40] = v[39:0];
    endtask

    task automatic drain();
        in_valid = 0; out_ready = 1;
        repeat (4) tick();
    endtask

    // Presents one beat and returns the first output beat and its latency in cycles.
    task automatic beat_once(input logic [3:0] md, input logic [11:0] sh,
                             output logic [511:0] d, output logic s, output int lat);
        mode = md; shift_set = sh; in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        d = out_data; s = out_sat;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 0; out_ready = 1; sat_clr = 0;
        mode = 0; shift_set = 0; p_vec = '0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", out_sat); end
        checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", sat_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_rounding();
        logic [511:0] d, ed; logic s; bit es; int lat;
        drain();
        p_vec = '0; set_lane(0, 4660);
        model(p_vec, 4'd0, 12'd4, ed, es);
        beat_once(4'd0, 12'd4, d, s, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL round_latency: got %0d want 2", lat); end
        checks++; if (d[15:0] !== 16'h0123) begin errors++; $display("FAIL round_lane0: got %h want 0123", d[15:0]); end
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL round_sat: got %b want 0", s); end
        checks++; if (d !== ed) begin errors++; $display("FAIL round_beat0: got %h want %h", d, ed); end
        p_vec = '0; set_lane(1, -20);
        model(p_vec, 4'd0, 12'd3, ed, es);
        beat_once(4'd0, 12'd3, d, s, lat);
        checks++; if (d[31:16] !== 16'hFFFE) begin errors++; $display("FAIL round_neg: got %h want fffe", d[31:16]); end
        checks++; if (d !== ed) begin errors++; $display("FAIL round_beat1: got %h want %h", d, ed); end
    endtask

    task automatic test_mode0_sat();
        logic [511:0] d; logic s; int lat;
        drain();
        p_vec = '0; set_lane(5, 65536); set_lane(6, -40000);
        beat_once(4'd0, 12'd0, d, s, lat);
        checks++; if (d[95:80] !== 16'h7FFF) begin errors++; $display("FAIL sat88_pos: got %h want 7fff", d[95:80]); end
        checks++; if (d[111:96] !== 16'h8000) begin errors++; $display("FAIL sat88_neg: got %h want 8000", d[111:96]); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL sat88_flag: got %b want 1", s); end
        tick();
        checks++; if (sat_cnt !== 16'd1) begin errors++; $display("FAIL sat88_cnt: got %0d want 1", sat_cnt); end
    endtask

    task automatic test_mode1();
        logic [511:0] d, ed; logic s; bit es; int lat;
        drain();
        p_vec = '0;
        set_lane(0, -200); set_lane(1, 64'hFF_0000_0005); set_lane(32, 10); set_lane(33, 600);
        model(p_vec, 4'd1, {6'd2, 6'd0}, ed, es);
        beat_once(4'd1, {6'd2, 6'd0}, d, s, lat);
        checks++; if (d[7:0] !== 8'h80) begin errors++; $display("FAIL m1_lane0: got %h want 80", d[7:0]); end
        checks++; if (d[15:8] !== 8'h05) begin errors++; $display("FAIL m1_hibits: got %h want 05", d[15:8]); end
        checks++; if (d[263:256] !== 8'h03) begin errors++; $display("FAIL m1_lane32: got %h want 03", d[263:256]); end
        checks++; if (d[271:264] !== 8'h7F) begin errors++; $display("FAIL m1_lane33: got %h want 7f", d[271:264]); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL m1_sat: got %b want 1", s); end
        checks++; if (d !== ed) begin errors++; $display("FAIL m1_beat: got %h want %h", d, ed); end
    endtask

    task automatic test_boundary();
        logic [511:0] d; logic s; int lat;
        drain();
        p_vec = '0; set_lane(0, -1); set_lane(1, (longint'(1) <<< 39) - 1);
        beat_once(4'd0, 12'd63, d, s, lat);
        checks++; if (d[15:0] !== 16'h0000) begin errors++; $display("FAIL shift63_neg: got %h want 0000", d[15:0]); end
        checks++; if (d[31:16] !== 16'h0001) begin errors++; $display("FAIL shift63_pos: got %h want 0001", d[31:16]); end
        for (int m = 0; m < 64; m++) set_lane(m, longint'(1) <<< 30);
        beat_once(4'd5, 12'd0, d, s, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL bad_mode_valid: latency got %0d want 2", lat); end
        checks++; if (d !== '0) begin errors++; $display("FAIL bad_mode_data: got %h want 0", d); end
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL bad_mode_sat: got %b want 0", s); end
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0;
        logic [511:0] held, exp_d;
        drain();
        p_vec = '0; mode = 0; shift_set = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid = (sent < 4);
            set_lane(0, sent + 1);
            out_ready = !(cyc >= 3 && cyc < 6);
            #1;
            if (cyc >= 3 && cyc < 6) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b want 1", cyc, out_valid); end
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c%0d: got %b want 0", cyc, in_ready); end
                if (cyc > 3) begin
                    checks++; if (out_data !== held) begin errors++; $display("FAIL bp_hold c%0d: got %h want %h", cyc, out_data, held); end
                end
                held = out_data;
            end
            if (out_valid && out_ready) begin
                exp_d = '0; exp_d[15:0] = 16'(got + 1);
                checks++; if (out_data !== exp_d) begin errors++; $display("FAIL bp_order #%0d: got %h want %h", got, out_data[15:0], exp_d[15:0]); end
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        checks++; if (got !== 4) begin errors++; $display("FAIL bp_count: got %0d beats want 4", got); end
    endtask

    task automatic test_sat_clr();
        logic [511:0] d; logic s; int lat;
        drain();
        p_vec = '0; set_lane(0, longint'(1) <<< 30);
        beat_once(4'd0, 12'd0, d, s, lat);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL clr_sat: got %b want 1", s); end
        sat_clr = 1;
        tick();
        sat_clr = 0;
        checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL clr_priority: got %0d want 0", sat_cnt); end
    endtask

    task automatic test_sat_cnt_saturate();
        drain();
        sat_clr = 1; tick(); sat_clr = 0;
        p_vec = '0; set_lane(0, longint'(1) <<< 30); mode = 0; shift_set = 0;
        in_valid = 1; repeat (20) tick();
        drain();
        checks++; if (sat_cnt !== 16'd20) begin errors++; $display("FAIL cnt_20: got %0d want 20", sat_cnt); end
        checks++; if (s_sat_cnt !== 4'hF) begin errors++; $display("FAIL cnt_top: got %h want f", s_sat_cnt); end
        in_valid = 1; repeat (3) tick();
        drain();
        checks++; if (s_sat_cnt !== 4'hF) begin errors++; $display("FAIL cnt_stick: got %h want f", s_sat_cnt); end
        checks++; if (sat_cnt !== 16'd23) begin errors++; $display("FAIL cnt_23: got %0d want 23", sat_cnt); end
    endtask

    task automatic test_random();
        logic [511:0] exp_q[$];
        bit exp_sat_q[$];
        logic [511:0] ed; bit es;
        int exp_cnt = 0, r;
        drain();
        rst_n = 0; tick(); rst_n = 1;
        for (int cyc = 0; cyc < 240; cyc++) begin
            in_valid = (cyc < 200) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0) || (cyc >= 200);
            r = $urandom_range(0, 9);
            mode = (r < 4) ? 4'd0 : (r < 8) ? 4'd1 : 4'($urandom_range(2, 15));
            shift_set[5:0]  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 24));
            shift_set[11:6] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 24));
            for (int m = 0; m < 64; m++) set_lane(m, rand_val());
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL rnd_extra: unexpected beat %h", out_data[63:0]);
                end else begin
                    ed = exp_q.pop_front(); es = exp_sat_q.pop_front();
                    checks++; if (out_data !== ed) begin errors++; $display("FAIL rnd_data c%0d: got %h want %h", cyc, out_data[127:0], ed[127:0]); end
                    checks++; if (out_sat !== es) begin errors++; $display("FAIL rnd_sat c%0d: got %b want %b", cyc, out_sat, es); end
                    if (es && exp_cnt < 65535) exp_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                model(p_vec, mode, shift_set, ed, es);
                exp_q.push_back(ed); exp_sat_q.push_back(es);
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_lost: %0d beats missing, want 0", exp_q.size()); end
        checks++; if (sat_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL rnd_cnt: got %0d want %0d", sat_cnt, exp_cnt); end
    endtask

    task automatic test_reset_midstream();
        logic [511:0] d; logic s; int lat;
        bit stale = 0;
        drain();
        p_vec = '0; set_lane(0, longint'(1) <<< 30);
        beat_once(4'd0, 12'd0, d, s, lat);
        in_valid = 1; tick(); tick();
        in_valid = 0; out_ready = 0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight: got %b want 1", out_valid); end
        rst_n = 0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", sat_cnt); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_data: got %h want 0", out_data); end
        rst_n = 1; out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) stale = 1;
        end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL mid_stale: got stale beat %b want 0", stale); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no completion want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rounding();
        test_mode0_sat();
        test_mode1();
        test_boundary();
        test_backpressure();
        test_sat_clr();
        test_sat_cnt_saturate();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
